// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types and constants: sequencer states, CA layout and
// default latency.
package hyperbus_pkg;

   localparam int unsigned HB_CA_W            = 48;
   localparam int unsigned HB_CA_IDX_HI       = 2;  // CA[47:32], first word on the bus
   localparam int unsigned HB_CA_IDX_MID      = 1;  // CA[31:16]
   localparam int unsigned HB_CA_IDX_LO       = 0;  // CA[15:0]
   localparam int unsigned HB_DEFAULT_LATENCY = 6;

   typedef enum logic [2:0] {
      HB_IDLE,
      HB_CMD0,
      HB_CMD1,
      HB_CMD2,
      HB_LAT,
      HB_DATA,
      HB_END
   } hb_txn_state_e;

   function automatic logic [15:0] hb_ca_word(input logic [HB_CA_W-1:0] ca,
                                              input int unsigned      idx);
      return ca[idx*16 +: 16];
   endfunction

endpackage

// File: rtl/hyperbus_txn_ctrl_if.sv
// Request, PHY and data-beat signals of the transaction sequencer.
// The front-end/PHY side uses master, the sequencer uses slave.
interface hyperbus_txn_ctrl_if #(
   parameter int unsigned MAX_BURST_W = 16,
   parameter int unsigned LAT_W       = 5
);
   logic                   trans_valid_i;
   logic                   trans_ready_o;
   logic                   trans_rw_i;
   logic                   trans_address_space_i;
   logic                   trans_burst_type_i;
   logic [31:0]            trans_address_i;
   logic [MAX_BURST_W-1:0] trans_burst_i;
   logic [LAT_W-1:0]       cfg_latency_i;
   logic [LAT_W-1:0]       cfg_cs_recovery_i;
   logic                   rwds_i;
   logic                   cs_no;
   logic                   ca_valid_o;
   logic [15:0]            ca_o;
   logic                   tx_valid_i;
   logic                   tx_ready_o;
   logic                   rx_valid_i;
   logic                   busy_o;
   logic                   done_o;

   modport master (
      output trans_valid_i, trans_rw_i, trans_address_space_i, trans_burst_type_i,
             trans_address_i, trans_burst_i, cfg_latency_i, cfg_cs_recovery_i,
             rwds_i, tx_valid_i, rx_valid_i,
      input  trans_ready_o, cs_no, ca_valid_o, ca_o, tx_ready_o, busy_o, done_o
   );

   modport slave (
      input  trans_valid_i, trans_rw_i, trans_address_space_i, trans_burst_type_i,
             trans_address_i, trans_burst_i, cfg_latency_i, cfg_cs_recovery_i,
             rwds_i, tx_valid_i, rx_valid_i,
      output trans_ready_o, cs_no, ca_valid_o, ca_o, tx_ready_o, busy_o, done_o
   );

endinterface

// File: rtl/hyperbus_cmd_addr_gen.sv
// Packs a latched request into the 48-bit HyperBus command-address.
// The low word carries only the sub-page offset, addr[2:0].
module hyperbus_cmd_addr_gen
   import hyperbus_pkg::*;
(
   input  logic               rw,
   input  logic               space,
   input  logic               burst_type,
   input  logic [31:0]        address,
   output logic [HB_CA_W-1:0] ca
);

   assign ca = {rw, space, burst_type, address[31:3], 13'd0, address[2:0]};

endmodule

// File: rtl/hyperbus_txn_ctrl.sv
// HyperBus transaction sequencer: CA issue, initial latency (optionally doubled
// by RWDS), data-beat counting and chip-select recovery.
module hyperbus_txn_ctrl
   import hyperbus_pkg::*;
#(
   parameter int unsigned MAX_BURST_W = 16,
   parameter int unsigned LAT_W       = 5
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   hyperbus_txn_ctrl_if.slave bus
);

   hb_txn_state_e          state, next;
   logic                   rw_q, space_q, bt_q, lat_double;
   logic [31:0]            addr_q;
   logic [MAX_BURST_W-1:0] burst_q, beat_cnt;
   logic [LAT_W-1:0]       lat_q, rec_q, rec_cnt, rec_eff;
   logic [LAT_W:0]         lat_cnt, lat_len;
   logic                   done_q, beat, zero_lat, burst_zero, enter_end;
   logic [HB_CA_W-1:0]     ca;

   hyperbus_cmd_addr_gen u_ca (
      .rw        (rw_q),
      .space     (space_q),
      .burst_type(bt_q),
      .address   (addr_q),
      .ca        (ca)
   );

   assign lat_len    = lat_double ? {lat_q, 1'b0} : {1'b0, lat_q};
   // Register-space writes carry no initial latency.
   assign zero_lat   = (!rw_q && space_q) || (lat_len == '0);
   assign burst_zero = (burst_q == '0);
   assign rec_eff    = (rec_q == '0) ? LAT_W'(1) : rec_q;
   assign beat       = (state == HB_DATA) && (rw_q ? bus.rx_valid_i : bus.tx_valid_i);
   assign enter_end  = (next == HB_END) && (state != HB_END);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= HB_IDLE;
      else         state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         HB_IDLE: if (bus.trans_valid_i) next = HB_CMD0;
         HB_CMD0: next = HB_CMD1;
         HB_CMD1: next = HB_CMD2;
         HB_CMD2: begin
            if (!zero_lat)       next = HB_LAT;
            else if (burst_zero) next = HB_END;
            else                 next = HB_DATA;
         end
         HB_LAT:  if (lat_cnt == (LAT_W+1)'(1)) next = burst_zero ? HB_END : HB_DATA;
         HB_DATA: if (beat && (beat_cnt == MAX_BURST_W'(1))) next = HB_END;
         HB_END:  if (rec_cnt == LAT_W'(1)) next = HB_IDLE;
         default: next = HB_IDLE;
      endcase
   end

   // Request fields and config are captured once, at accept.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rw_q       <= 1'b0;
         space_q    <= 1'b0;
         bt_q       <= 1'b0;
         addr_q     <= '0;
         burst_q    <= '0;
         lat_q      <= '0;
         rec_q      <= '0;
         lat_double <= 1'b0;
         lat_cnt    <= '0;
         beat_cnt   <= '0;
         rec_cnt    <= '0;
         done_q     <= 1'b0;
      end else begin
         if (state == HB_IDLE && bus.trans_valid_i) begin
            rw_q    <= bus.trans_rw_i;
            space_q <= bus.trans_address_space_i;
            bt_q    <= bus.trans_burst_type_i;
            addr_q  <= bus.trans_address_i;
            burst_q <= bus.trans_burst_i;
            lat_q   <= bus.cfg_latency_i;
            rec_q   <= bus.cfg_cs_recovery_i;
         end
         if (state == HB_CMD0) lat_double <= bus.rwds_i;
         if (state == HB_CMD2) begin
            lat_cnt  <= lat_len;
            beat_cnt <= burst_q;
         end
         if (state == HB_LAT) lat_cnt <= lat_cnt - (LAT_W+1)'(1);
         if (beat)            beat_cnt <= beat_cnt - MAX_BURST_W'(1);
         if (enter_end)            rec_cnt <= rec_eff;
         else if (state == HB_END) rec_cnt <= rec_cnt - LAT_W'(1);
         done_q <= enter_end;
      end
   end

   always_comb begin
      bus.trans_ready_o = 1'b0;
      bus.cs_no         = 1'b1;
      bus.ca_valid_o    = 1'b0;
      bus.ca_o          = '0;
      bus.tx_ready_o    = 1'b0;
      bus.busy_o        = 1'b1;
      bus.done_o        = done_q;
      case (state)
         HB_IDLE: begin
            bus.trans_ready_o = 1'b1;
            bus.busy_o        = 1'b0;
         end
         HB_CMD0: begin
            bus.cs_no      = 1'b0;
            bus.ca_valid_o = 1'b1;
            bus.ca_o       = hb_ca_word(ca, HB_CA_IDX_HI);
         end
         HB_CMD1: begin
            bus.cs_no      = 1'b0;
            bus.ca_valid_o = 1'b1;
            bus.ca_o       = hb_ca_word(ca, HB_CA_IDX_MID);
         end
         HB_CMD2: begin
            bus.cs_no      = 1'b0;
            bus.ca_valid_o = 1'b1;
            bus.ca_o       = hb_ca_word(ca, HB_CA_IDX_LO);
         end
         HB_LAT:  bus.cs_no = 1'b0;
         HB_DATA: begin
            bus.cs_no      = 1'b0;
            bus.tx_ready_o = !rw_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hyperbus_txn_ctrl.sv
// Directed bench for hyperbus_txn_ctrl: a timestamp model of each transaction
// is compared against the outputs every cycle, plus literal timing/CA checks.
module tb_hyperbus_txn_ctrl;
   import hyperbus_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   hyperbus_txn_ctrl_if #(.MAX_BURST_W(16), .LAT_W(5)) bus ();

   hyperbus_txn_ctrl #(.MAX_BURST_W(16), .LAT_W(5)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Model: each transaction is described by its accept cycle and the derived
   // phase boundaries (k = cycles since accept).
   bit          m_active = 0;
   bit          m_end_known;
   int          m_acc, m_dstart, m_end_k, m_left, m_rec, m_burst, m_n;
   logic        m_rw, m_space;
   logic [47:0] m_ca;

   int          done_cnt = 0;
   int          done_cyc = 0;
   int          txr_first = -1;
   int          txr_cnt = 0;
   int          beat_cnt = 0;
   logic [15:0] ca_log[$];

   always @(negedge clk) begin : model_cmp
      logic        e_rdy, e_cs, e_cav, e_txr, e_busy, e_done, in_data;
      logic [15:0] e_ca;
      int          k;
      e_rdy = 1; e_cs = 1; e_cav = 0; e_ca = '0; e_txr = 0; e_busy = 0; e_done = 0;
      in_data = 0; k = 0;
      if (!rst_n) m_active = 0;
      else if (m_active) begin
         k = cyc - m_acc;
         if (m_end_known && k >= m_end_k + m_rec) m_active = 0;
      end
      if (m_active) begin
         e_rdy = 0; e_busy = 1;
         if (k <= 3) begin
            e_cs = 0; e_cav = 1; e_ca = m_ca[47-16*(k-1) -: 16];
         end else if (k < m_dstart) e_cs = 0;
         else if (!m_end_known || k < m_end_k) begin
            e_cs = 0; e_txr = !m_rw; in_data = 1;
         end else e_done = (k == m_end_k);
      end
      chk($sformatf("cycle %0d outputs{rdy,cs,cav,ca,txr,busy,done}", cyc),
          {26'd0, bus.trans_ready_o, bus.cs_no, bus.ca_valid_o, bus.ca_o,
           bus.tx_ready_o, bus.busy_o, bus.done_o},
          {26'd0, e_rdy, e_cs, e_cav, e_ca, e_txr, e_busy, e_done});
      if (rst_n) begin
         if (m_active && k == 1) begin
            m_dstart = 4 + ((!m_rw && m_space) ? 0 : m_n * (bus.rwds_i ? 2 : 1));
            if (m_burst == 0) begin m_end_known = 1; m_end_k = m_dstart; end
         end
         if (in_data && (m_rw ? bus.rx_valid_i : bus.tx_valid_i)) begin
            m_left--;
            if (m_left == 0) begin m_end_known = 1; m_end_k = k + 1; end
         end
         if (e_rdy && bus.trans_valid_i) begin
            m_active    = 1;
            m_acc       = cyc;
            m_end_known = 0;
            m_dstart    = 1 << 20;
            m_rw        = bus.trans_rw_i;
            m_space     = bus.trans_address_space_i;
            m_burst     = int'(bus.trans_burst_i);
            m_left      = m_burst;
            m_n         = int'(bus.cfg_latency_i);
            m_rec       = (bus.cfg_cs_recovery_i == 0) ? 1 : int'(bus.cfg_cs_recovery_i);
            m_ca        = {bus.trans_rw_i, bus.trans_address_space_i, bus.trans_burst_type_i,
                           bus.trans_address_i[31:3], 13'd0, bus.trans_address_i[2:0]};
         end
         if (bus.done_o) begin done_cnt++; done_cyc = cyc; end
         if (bus.ca_valid_o) ca_log.push_back(bus.ca_o);
         if (bus.tx_ready_o) begin
            txr_cnt++;
            if (txr_first < 0) txr_first = cyc;
            if (bus.tx_valid_i) beat_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_txn(input logic rw, space, bt, input logic [31:0] addr,
                            input int burst, n, rec, output int acc_t);
      int b;
      bus.trans_rw_i            = rw;
      bus.trans_address_space_i = space;
      bus.trans_burst_type_i    = bt;
      bus.trans_address_i       = addr;
      bus.trans_burst_i         = 16'(burst);
      bus.cfg_latency_i         = 5'(n);
      bus.cfg_cs_recovery_i     = 5'(rec);
      bus.trans_valid_i         = 1;
      b = 0;
      while (!bus.trans_ready_o && b < 50) begin tick(); b++; end
      if (!bus.trans_ready_o) chk("accept_timeout", 0, 1);
      acc_t = cyc;
      txr_cnt = 0; txr_first = -1; beat_cnt = 0; ca_log.delete();
      tick();
      // Scramble request and config to show they were latched at accept.
      bus.trans_valid_i     = 0;
      bus.trans_rw_i        = ~rw;
      bus.trans_address_i   = 32'hFFFF_FFFF;
      bus.trans_burst_i     = 16'd7;
      bus.cfg_latency_i     = 5'd1;
      bus.cfg_cs_recovery_i = 5'd9;
   endtask

   task automatic run_txn(input logic rw, space, bt, input logic [31:0] addr,
                          input int burst, n, rec, input logic rwds0, input int gap,
                          output int acc_t, done_k, ready_k);
      int   d0, b, k;
      logic v;
      d0 = done_cnt;
      start_txn(rw, space, bt, addr, burst, n, rec, acc_t);
      done_k = -1;
      b = 0;
      while (done_cnt == d0 && b < 300) begin
         k = cyc - acc_t;
         bus.rwds_i     = (k == 1) ? rwds0 : ~rwds0;
         v              = (gap == 0) ? 1'b1 : ((k % (gap + 1)) == 0);
         bus.rx_valid_i = v;
         bus.tx_valid_i = v;
         tick();
         b++;
      end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
      else done_k = done_cyc - acc_t;
      bus.rx_valid_i = 0; bus.tx_valid_i = 0; bus.rwds_i = 0;
      b = 0;
      while (!bus.trans_ready_o && b < 50) begin tick(); b++; end
      ready_k = cyc - acc_t;
   endtask

   initial begin
      int t, t0, dk, rk, d0;
      bus.trans_valid_i = 0; bus.trans_rw_i = 0; bus.trans_address_space_i = 0;
      bus.trans_burst_type_i = 0; bus.trans_address_i = '0; bus.trans_burst_i = '0;
      bus.cfg_latency_i = 5'(HB_DEFAULT_LATENCY); bus.cfg_cs_recovery_i = '0;
      bus.rwds_i = 0; bus.tx_valid_i = 0; bus.rx_valid_i = 0;
      repeat (3) tick();
      chk("reset_state", {41'd0, bus.trans_ready_o, bus.cs_no, bus.ca_valid_o, bus.tx_ready_o,
                          bus.busy_o, bus.done_o, |bus.ca_o}, 48'b110000_0);
      rst_n = 1;
      tick();

      // Linear memory read, N=6, no doubling.
      run_txn(1, 0, 1, 32'h0000_1235, 4, HB_DEFAULT_LATENCY, 3, 0, 0, t, dk, rk);
      chk("t1_ca_count", ca_log.size(), 3);
      if (ca_log.size() == 3) begin
         chk("t1_ca0", ca_log[0], 16'hA000);
         chk("t1_ca1", ca_log[1], 16'h0246);
         chk("t1_ca2", ca_log[2], 16'h0005);
      end
      chk("t1_done_k", dk, 14);
      chk("t1_ready_k", rk, 17);

      // Same read, RWDS high in CMD0 doubles latency.
      run_txn(1, 0, 1, 32'h0000_1235, 4, HB_DEFAULT_LATENCY, 3, 1, 0, t, dk, rk);
      chk("t2_done_k", dk, 20);
      chk("t2_ready_k", rk, 23);

      // Register write: zero latency.
      run_txn(0, 1, 1, 32'h0000_0040, 1, HB_DEFAULT_LATENCY, 1, 0, 0, t, dk, rk);
      chk("t3_ca0", ca_log.size() > 0 ? ca_log[0] : 16'hxxxx, 16'h6000);
      chk("t3_first_tx_ready_k", txr_first - t, 4);
      chk("t3_beats", beat_cnt, 1);
      chk("t3_done_k", dk, 5);
      chk("t3_ready_k", rk, 6);

      // Memory write with tx_valid every third cycle.
      d0 = done_cnt;
      run_txn(0, 0, 0, 32'h0000_0100, 3, HB_DEFAULT_LATENCY, 2, 0, 2, t, dk, rk);
      chk("t4_beats", beat_cnt, 3);
      chk("t4_tx_ready_cycles", txr_cnt, 9);
      chk("t4_done_count", done_cnt - d0, 1);
      chk("t4_done_k", dk, 19);
      chk("t4_ready_k", rk, 21);

      // Burst 0 with recovery 0, then a back-to-back zero-latency request.
      run_txn(1, 0, 1, 32'h0, 0, HB_DEFAULT_LATENCY, 0, 0, 0, t0, dk, rk);
      chk("t5_done_k", dk, 10);
      chk("t5_ready_k", rk, 11);
      chk("t5_tx_ready_cycles", txr_cnt, 0);
      run_txn(0, 0, 1, 32'h8, 0, 0, 0, 0, 0, t, dk, rk);
      chk("t5b_accept_gap", t - t0, 11);
      chk("t5b_done_k", dk, 4);
      chk("t5b_ready_k", rk, 5);

      // Reset in the middle of the latency phase.
      d0 = done_cnt;
      start_txn(1, 0, 1, 32'h0000_1235, 4, HB_DEFAULT_LATENCY, 3, t);
      repeat (5) tick();
      rst_n = 0;
      #1;
      chk("t6_reset_cs_ready_busy", {45'd0, bus.cs_no, bus.trans_ready_o, bus.busy_o}, 48'b110);
      tick(); tick();
      rst_n = 1;
      repeat (3) tick();
      chk("t6_no_done", done_cnt - d0, 0);
      run_txn(1, 0, 1, 32'h0000_1235, 4, HB_DEFAULT_LATENCY, 3, 0, 0, t, dk, rk);
      chk("t6_after_done_k", dk, 14);
      chk("t6_after_ready_k", rk, 17);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
